plab4_net_terminal_inject: RTL and testbench

Injection stage that sits directly upstream of a router's terminal input port (port 1). It accepts client `{dest, payload}` requests over val/rdy and builds full network messages. Each message is stamped with this router's id as source and a rolling opaque sequence tag. It throttles the client so that at most `p_max_inflight` messages are outstanding, and presents the result to the router through a one-entry registered output stage.

---
 rtl/plab4_net_terminal_inject.sv | 84 ++++++++
 tb/tb_plab4_net_terminal_inject.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/plab4_net_terminal_inject.sv
// Terminal injection stage: wraps client {dest, payload} requests into full
// network messages and throttles the client to a bounded number in flight.

`ifndef VC_NET_MSG_NBITS
`define VC_NET_MSG_NBITS(p_,o_,s_)         ((p_)+(o_)+2*(s_))
`define VC_NET_MSG_PAYLOAD_FIELD(p_,o_,s_) (p_)-1 : 0
`define VC_NET_MSG_OPAQUE_FIELD(p_,o_,s_)  (o_)+(p_)-1 : (p_)
`define VC_NET_MSG_SRC_FIELD(p_,o_,s_)     (s_)+(o_)+(p_)-1 : (o_)+(p_)
`define VC_NET_MSG_DEST_FIELD(p_,o_,s_)    2*(s_)+(o_)+(p_)-1 : (s_)+(o_)+(p_)
`endif

module plab4_net_terminal_inject #(
    parameter int p_payload_nbits = 32,
    parameter int p_opaque_nbits  = 3,
    parameter int p_srcdest_nbits = 3,
    parameter int p_router_id     = 0,
    parameter int p_num_routers   = 8,
    parameter int p_max_inflight  = 4,
    localparam int c_net_msg_nbits =
        `VC_NET_MSG_NBITS(p_payload_nbits, p_opaque_nbits, p_srcdest_nbits)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_val,
    output logic                       req_rdy,
    input  logic [p_srcdest_nbits-1:0] req_dest,
    input  logic [p_payload_nbits-1:0] req_payload,
    output logic                       out_val,
    input  logic                       out_rdy,
    output logic [c_net_msg_nbits-1:0] out_msg,
    input  logic                       done,
    output logic [3:0]                 inflight,
    output logic                       bad_dest
);

    logic [p_opaque_nbits-1:0]  tag_reg;
    logic [c_net_msg_nbits-1:0] msg_next;
    logic                       accept;
    logic                       dest_legal;
    logic                       accept_legal;

    // Ready only looks at the output slot and the credit count, never at req_val.
    assign req_rdy      = !reset && (!out_val || out_rdy)
                          && (inflight < 4'(p_max_inflight));
    assign accept       = req_val && req_rdy;
    assign dest_legal   = {1'b0, req_dest} < (p_srcdest_nbits + 1)'(p_num_routers);
    assign accept_legal = accept && dest_legal;

    always_comb begin
        msg_next = '0;
        msg_next[`VC_NET_MSG_DEST_FIELD(p_payload_nbits, p_opaque_nbits, p_srcdest_nbits)]    = req_dest;
        msg_next[`VC_NET_MSG_SRC_FIELD(p_payload_nbits, p_opaque_nbits, p_srcdest_nbits)]     = p_srcdest_nbits'(p_router_id);
        msg_next[`VC_NET_MSG_OPAQUE_FIELD(p_payload_nbits, p_opaque_nbits, p_srcdest_nbits)]  = tag_reg;
        msg_next[`VC_NET_MSG_PAYLOAD_FIELD(p_payload_nbits, p_opaque_nbits, p_srcdest_nbits)] = req_payload;
    end

    // A new accept overwrites the slot even while it drains, giving one message per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_val  <= 1'b0;
            out_msg  <= '0;
            tag_reg  <= '0;
            inflight <= '0;
            bad_dest <= 1'b0;
        end else begin
            bad_dest <= accept && !dest_legal;

            if (accept_legal) begin
                out_msg <= msg_next;
                out_val <= 1'b1;
                tag_reg <= tag_reg + p_opaque_nbits'(1);
            end else if (out_val && out_rdy) begin
                out_val <= 1'b0;
            end

            if (accept_legal && !done) begin
                inflight <= inflight + 4'd1;
            end else if (!accept_legal && done && (inflight != 4'd0)) begin
                inflight <= inflight - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_plab4_net_terminal_inject.sv
// Directed bench for plab4_net_terminal_inject with hand-computed message images.

module tb_plab4_net_terminal_inject;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_val;
    logic        req_rdy;
    logic [2:0]  req_dest;
    logic [31:0] req_payload;
    logic        out_val;
    logic        out_rdy;
    logic [40:0] out_msg;
    logic        done;
    logic [3:0]  inflight;
    logic        bad_dest;

    int total_checks = 0;
    int passed_checks = 0;

    plab4_net_terminal_inject #(
        .p_payload_nbits (32),
        .p_opaque_nbits  (3),
        .p_srcdest_nbits (3),
        .p_router_id     (2),
        .p_num_routers   (6),
        .p_max_inflight  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_val     (req_val),
        .req_rdy     (req_rdy),
        .req_dest    (req_dest),
        .req_payload (req_payload),
        .out_val     (out_val),
        .out_rdy     (out_rdy),
        .out_msg     (out_msg),
        .done        (done),
        .inflight    (inflight),
        .bad_dest    (bad_dest)
    );

    always #5 clk = ~clk;

    // Message layout MSB..LSB: dest | src | opaque | payload; this instance's src is 2.
    function automatic logic [40:0] make_msg(input logic [2:0] d, input logic [2:0] op,
                                             input logic [31:0] pl);
        return {d, 3'd2, op, pl};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        total_checks++;
        if (actual === expected) passed_checks++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    endtask

    task automatic applyStimulus(input logic val, input logic [2:0] dest,
                                 input logic [31:0] payload, input logic rdy,
                                 input logic dn);
        req_val     = val;
        req_dest    = dest;
        req_payload = payload;
        out_rdy     = rdy;
        done        = dn;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("rdy_in_reset", 64'(req_rdy), 64'd0);
        reset = 1'b0;
        #1;
        checkOutput("rst_out_val", 64'(out_val), 64'd0);
        checkOutput("rst_out_msg", 64'(out_msg), 64'd0);
        checkOutput("rst_inflight", 64'(inflight), 64'd0);
        checkOutput("rst_bad_dest", 64'(bad_dest), 64'd0);

        // Single send
        applyStimulus(1'b1, 3'd3, 32'hCAFEF00D, 1'b1, 1'b0);
        #1;
        checkOutput("single_rdy", 64'(req_rdy), 64'd1);
        tick();
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("single_val", 64'(out_val), 64'd1);
        checkOutput("single_msg", 64'(out_msg), 64'(make_msg(3'd3, 3'd0, 32'hCAFEF00D)));
        checkOutput("single_inflight", 64'(inflight), 64'd1);
        tick();
        checkOutput("single_drain", 64'(out_val), 64'd0);

        // Done with nothing outstanding saturates at zero
        do_reset();
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b1);
        tick();
        checkOutput("done_sat", 64'(inflight), 64'd0);

        // Tag wrap and full throughput
        do_reset();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 3'(i % 6), 32'h1000_0000 + 32'(i), 1'b1, i > 0);
            tick();
            checkOutput("wrap_val", 64'(out_val), 64'd1);
            checkOutput("wrap_msg", 64'(out_msg),
                        64'(make_msg(3'(i % 6), 3'(i % 8), 32'h1000_0000 + 32'(i))));
            checkOutput("wrap_inflight", 64'(inflight), 64'd1);
        end
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        tick();
        checkOutput("wrap_idle", 64'(out_val), 64'd0);

        // In-flight limit
        do_reset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 3'd1, 32'h5555_0000 + 32'(i), 1'b1, 1'b0);
            #1;
            checkOutput("lim_rdy", 64'(req_rdy), (i < 4) ? 64'd1 : 64'd0);
            tick();
            checkOutput("lim_inflight", 64'(inflight), (i < 4) ? 64'(i + 1) : 64'd4);
        end
        applyStimulus(1'b1, 3'd1, 32'h5555_0005, 1'b1, 1'b1);
        #1;
        checkOutput("lim_rdy_done", 64'(req_rdy), 64'd0);
        tick();
        applyStimulus(1'b1, 3'd1, 32'h5555_0005, 1'b1, 1'b0);
        checkOutput("lim_after_done", 64'(inflight), 64'd3);
        #1;
        checkOutput("lim_rdy_back", 64'(req_rdy), 64'd1);
        tick();
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("lim_fifth_msg", 64'(out_msg), 64'(make_msg(3'd1, 3'd4, 32'h5555_0005)));
        checkOutput("lim_fifth_inflight", 64'(inflight), 64'd4);

        // Backpressure
        do_reset();
        applyStimulus(1'b1, 3'd2, 32'hAAAA_0001, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 3'd4, 32'hBBBB_0002, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("bp_rdy", 64'(req_rdy), 64'd0);
            tick();
            checkOutput("bp_val", 64'(out_val), 64'd1);
            checkOutput("bp_msg", 64'(out_msg), 64'(make_msg(3'd2, 3'd0, 32'hAAAA_0001)));
        end
        out_rdy = 1'b1;
        #1;
        checkOutput("bp_release_rdy", 64'(req_rdy), 64'd1);
        tick();
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("bp_second_val", 64'(out_val), 64'd1);
        checkOutput("bp_second_msg", 64'(out_msg), 64'(make_msg(3'd4, 3'd1, 32'hBBBB_0002)));
        checkOutput("bp_inflight", 64'(inflight), 64'd2);

        // Illegal destinations (6 and 7 with six routers)
        do_reset();
        applyStimulus(1'b1, 3'd6, 32'hDEAD_0006, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 3'd7, 32'hDEAD_0007, 1'b1, 1'b0);
        checkOutput("bad6_pulse", 64'(bad_dest), 64'd1);
        checkOutput("bad6_val", 64'(out_val), 64'd0);
        checkOutput("bad6_inflight", 64'(inflight), 64'd0);
        tick();
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("bad7_pulse", 64'(bad_dest), 64'd1);
        checkOutput("bad7_val", 64'(out_val), 64'd0);
        tick();
        checkOutput("bad_pulse_end", 64'(bad_dest), 64'd0);
        applyStimulus(1'b1, 3'd5, 32'hC0DE_0005, 1'b1, 1'b0);
        tick();
        checkOutput("legal_after_bad", 64'(out_msg), 64'(make_msg(3'd5, 3'd0, 32'hC0DE_0005)));
        checkOutput("legal_no_pulse", 64'(bad_dest), 64'd0);
        checkOutput("legal_inflight", 64'(inflight), 64'd1);

        // Reset mid-stream, with a done pulse that must be ignored
        applyStimulus(1'b1, 3'd0, 32'h1111_0001, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 3'd0, 32'h1111_0002, 1'b1, 1'b0);
        tick();
        checkOutput("mid_inflight", 64'(inflight), 64'd3);
        checkOutput("mid_val", 64'(out_val), 64'd1);
        reset = 1'b1;
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b1);
        tick();
        checkOutput("mid_rst_val", 64'(out_val), 64'd0);
        checkOutput("mid_rst_msg", 64'(out_msg), 64'd0);
        checkOutput("mid_rst_inflight", 64'(inflight), 64'd0);
        checkOutput("mid_rst_rdy", 64'(req_rdy), 64'd0);
        reset = 1'b0;
        applyStimulus(1'b1, 3'd3, 32'h2222_0000, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("post_rst_msg", 64'(out_msg), 64'(make_msg(3'd3, 3'd0, 32'h2222_0000)));
        checkOutput("post_rst_inflight", 64'(inflight), 64'd1);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
